// File: rtl/grid_scanner.sv
// rtl/grid_scanner.sv - 8x8 grid row scanner with dwell timing, refresh and frame counting
// Optional inter-row blanking cycle enabled by defining SCAN_BLANK_EN.
module grid_scanner #(
    parameter int DWELL = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] grid_in,
    input  logic        grid_valid,
    output logic        grid_ready,
    input  logic        enable,
    output logic [7:0]  row_sel,
    output logic [7:0]  col_data,
    output logic        frame_done,
    output logic [7:0]  frame_cnt
);

    localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
`ifdef SCAN_BLANK_EN
        S_BLANK = 2'd2,
`endif
        S_DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  row_q, row_d;
    logic [7:0]  dwell_q, dwell_d;
    logic [63:0] held_q, held_d;
    logic        have_q, have_d;
    logic [7:0]  cnt_q, cnt_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            row_q   <= 3'd0;
            dwell_q <= 8'd0;
            held_q  <= 64'd0;
            have_q  <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            dwell_q <= dwell_d;
            held_q  <= held_d;
            have_q  <= have_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        dwell_d    = dwell_q;
        held_d     = held_q;
        have_d     = have_q;
        cnt_d      = cnt_q;
        grid_ready = 1'b0;
        row_sel    = 8'd0;
        col_data   = 8'd0;
        frame_done = 1'b0;

        case (state_q)
            S_IDLE: begin
                // reset gates grid_ready so it drops the moment reset asserts
                grid_ready = enable & reset;
                if (enable) begin
                    if (grid_valid) begin
                        held_d  = grid_in;
                        have_d  = 1'b1;
                        state_d = S_SCAN;
                        row_d   = 3'd0;
                        dwell_d = 8'd0;
                    end else if (have_q) begin
                        state_d = S_SCAN;
                        row_d   = 3'd0;
                        dwell_d = 8'd0;
                    end
                end
            end

            S_SCAN: begin
                row_sel  = 8'd1 << row_q;
                col_data = held_q[{row_q, 3'b000} +: 8];
                if (dwell_q == DWELL_LAST) begin
                    dwell_d = 8'd0;
                    if (row_q == 3'd7) begin
                        state_d = S_DONE;
                    end else begin
                        row_d = row_q + 3'd1;
`ifdef SCAN_BLANK_EN
                        state_d = S_BLANK;
`endif
                    end
                end else begin
                    dwell_d = dwell_q + 8'd1;
                end
            end

`ifdef SCAN_BLANK_EN
            S_BLANK: begin
                state_d = S_SCAN;
            end
`endif

            S_DONE: begin
                frame_done = 1'b1;
                cnt_d      = cnt_q + 8'd1;
                row_d      = 3'd0;
                state_d    = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_grid_scanner.sv
// tb/tb_grid_scanner.sv - table-driven self-checking bench for grid_scanner (DWELL=4 and DWELL=1)
module tb_grid_scanner;

    logic        clk;
    logic        reset;
    logic [63:0] grid_in, grid_in1;
    logic        grid_valid, grid_valid1;
    logic        grid_ready, grid_ready1;
    logic        enable, enable1;
    logic [7:0]  row_sel, row_sel1;
    logic [7:0]  col_data, col_data1;
    logic        frame_done, frame_done1;
    logic [7:0]  frame_cnt, frame_cnt1;

    int n_checks = 0;
    int n_fail   = 0;

    grid_scanner #(.DWELL(4)) dut (
        .clk(clk), .reset(reset), .grid_in(grid_in), .grid_valid(grid_valid),
        .grid_ready(grid_ready), .enable(enable), .row_sel(row_sel),
        .col_data(col_data), .frame_done(frame_done), .frame_cnt(frame_cnt)
    );

    grid_scanner #(.DWELL(1)) dut1 (
        .clk(clk), .reset(reset), .grid_in(grid_in1), .grid_valid(grid_valid1),
        .grid_ready(grid_ready1), .enable(enable1), .row_sel(row_sel1),
        .col_data(col_data1), .frame_done(frame_done1), .frame_cnt(frame_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] row;
        logic [7:0] sel;
        logic [7:0] col;
    } row_vec_t;

    row_vec_t tbl[8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        int pulses;
        bit found;
        bit activity;
        bit seen_row7;

        tbl[0] = '{3'd0, 8'h01, 8'hEF};
        tbl[1] = '{3'd1, 8'h02, 8'hCD};
        tbl[2] = '{3'd2, 8'h04, 8'hAB};
        tbl[3] = '{3'd3, 8'h08, 8'h89};
        tbl[4] = '{3'd4, 8'h10, 8'h67};
        tbl[5] = '{3'd5, 8'h20, 8'h45};
        tbl[6] = '{3'd6, 8'h40, 8'h23};
        tbl[7] = '{3'd7, 8'h80, 8'h01};

        reset = 1'b0;
        enable = 1'b1;  grid_valid = 1'b0;  grid_in = 64'd0;
        enable1 = 1'b0; grid_valid1 = 1'b0; grid_in1 = 64'd0;
        step();
        step();
        check("rst_grid_ready", grid_ready, 1'b0);
        check("rst_row_sel", row_sel, 8'h00);
        check("rst_col_data", col_data, 8'h00);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_frame_cnt", frame_cnt, 8'h00);
        reset = 1'b1;
        step();
        check("post_rst_grid_ready", grid_ready, 1'b1);
        step();
        check("post_rst_no_scan", row_sel, 8'h00);

        // first frame, with a competing grid offered throughout the scan
        grid_in = 64'h0123456789ABCDEF;
        grid_valid = 1'b1;
        check("idle_ready", grid_ready, 1'b1);
        step();
        grid_in = 64'h00000000000000FF;
        for (int r = 0; r < 8; r++) begin
            for (int d = 0; d < 4; d++) begin
                check($sformatf("f1_row%0d_d%0d_sel", tbl[r].row, d), row_sel, tbl[r].sel);
                check($sformatf("f1_row%0d_d%0d_col", tbl[r].row, d), col_data, tbl[r].col);
                check($sformatf("f1_row%0d_d%0d_ready", tbl[r].row, d), grid_ready, 1'b0);
                check($sformatf("f1_row%0d_d%0d_done", tbl[r].row, d), frame_done, 1'b0);
                step();
            end
`ifdef SCAN_BLANK_EN
            if (r < 7) begin
                check($sformatf("f1_blank%0d_sel", r), row_sel, 8'h00);
                check($sformatf("f1_blank%0d_col", r), col_data, 8'h00);
                step();
            end
`endif
        end
        check("f1_done", frame_done, 1'b1);
        check("f1_done_sel", row_sel, 8'h00);
        check("f1_done_col", col_data, 8'h00);
        check("f1_done_ready", grid_ready, 1'b0);
        step();
        check("f1_idle_done", frame_done, 1'b0);
        check("f1_frame_cnt", frame_cnt, 8'd1);
        check("f1_idle_ready", grid_ready, 1'b1);
        step();
        check("f2_row0_sel", row_sel, 8'h01);
        check("f2_row0_col", col_data, 8'hFF);
        grid_valid = 1'b0;

        // asynchronous reset during row 3
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            step();
            if (row_sel == 8'h08) found = 1'b1;
        end
        check("reach_row3", found, 1'b1);
        check("row3_col", col_data, 8'h00);
        reset = 1'b0;
        #1;
        check("async_rst_sel", row_sel, 8'h00);
        check("async_rst_col", col_data, 8'h00);
        check("async_rst_cnt", frame_cnt, 8'h00);
        check("async_rst_ready", grid_ready, 1'b0);
        step();
        check("in_rst_done", frame_done, 1'b0);
        reset = 1'b1;
        activity = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (row_sel != 8'h00 || frame_done) activity = 1'b1;
        end
        check("no_rescan_after_rst", activity, 1'b0);
        check("ready_after_rst", grid_ready, 1'b1);

        // diagonal grid then 256 frames of refresh to wrap the counter
        grid_in = 64'h8040201008040201;
        grid_valid = 1'b1;
        step();
        grid_valid = 1'b0;
        check("diag_row0_sel", row_sel, 8'h01);
        check("diag_row0_col", col_data, 8'h01);
        pulses = 0;
        seen_row7 = 1'b0;
        for (int i = 0; i < 12000 && pulses < 256; i++) begin
            step();
            if (frame_done) pulses++;
            if (pulses == 1 && !seen_row7 && row_sel == 8'h80) begin
                seen_row7 = 1'b1;
                check("refresh_row7_col", col_data, 8'h80);
            end
        end
        check("wrap_pulses", pulses, 256);
        check("refresh_seen", seen_row7, 1'b1);
        step();
        check("frame_cnt_wrap", frame_cnt, 8'h00);

        // DWELL=1 frame with enable dropped during row 2
        enable1 = 1'b1;
        grid_in1 = 64'h0123456789ABCDEF;
        grid_valid1 = 1'b1;
        step();
        grid_valid1 = 1'b0;
        for (int r = 0; r < 8; r++) begin
            check($sformatf("d1_row%0d_sel", r), row_sel1, tbl[r].sel);
            check($sformatf("d1_row%0d_col", r), col_data1, tbl[r].col);
            if (r == 2) enable1 = 1'b0;
            step();
`ifdef SCAN_BLANK_EN
            if (r < 7) begin
                check($sformatf("d1_blank%0d_sel", r), row_sel1, 8'h00);
                step();
            end
`endif
        end
        check("d1_done", frame_done1, 1'b1);
        check("d1_done_sel", row_sel1, 8'h00);
        step();
        check("d1_idle_ready", grid_ready1, 1'b0);
        check("d1_idle_done", frame_done1, 1'b0);
        check("d1_frame_cnt", frame_cnt1, 8'd1);
        activity = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (row_sel1 != 8'h00 || frame_done1) activity = 1'b1;
        end
        check("d1_no_rescan", activity, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
